// File: rtl/debug_console_wb_pkg.sv
// Shared register map, STATUS layout and default result codes for the debug console.
package debug_console_pkg;

   localparam logic [2:0] REG_TXDATA = 3'd0;
   localparam logic [2:0] REG_STATUS = 3'd1;
   localparam logic [2:0] REG_RESULT = 3'd2;
   localparam logic [2:0] REG_CTRL   = 3'd3;

   localparam int ST_LEVEL_W = 9;
   localparam int ST_EMPTY   = 16;
   localparam int ST_FULL    = 17;
   localparam int ST_DONE    = 24;
   localparam int ST_PASS    = 25;
   localparam int ST_FINISH  = 26;

   localparam logic [31:0] DEF_PASS_CODE   = 32'h1;
   localparam logic [31:0] DEF_FAIL_CODE   = 32'h0;
   localparam logic [31:0] DEF_FINISH_CODE = 32'h90;

   // Assemble the STATUS word from its fields; unused bits read as zero.
   function automatic logic [31:0] pack_status(input logic [ST_LEVEL_W-1:0] level,
                                               input logic empty, full, done, pass, finish);
      logic [31:0] s;
      s                   = '0;
      s[ST_LEVEL_W-1:0]   = level;
      s[ST_EMPTY]         = empty;
      s[ST_FULL]          = full;
      s[ST_DONE]          = done;
      s[ST_PASS]          = pass;
      s[ST_FINISH]        = finish;
      return s;
   endfunction

endpackage

// File: rtl/debug_console_wb_if.sv
// Pipelined Wishbone slave bus bundle for the debug console.
interface debug_console_wb_if;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic        wb_we_i;
   logic [31:0] wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [3:0]  wb_sel_i;
   logic        wb_stall_o;
   logic        wb_ack_o;
   logic [31:0] wb_dat_o;
   logic        wb_err_o;

   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
      input  wb_stall_o, wb_ack_o, wb_dat_o, wb_err_o
   );

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
      output wb_stall_o, wb_ack_o, wb_dat_o, wb_err_o
   );
endinterface

// File: rtl/debug_console_wb_fifo.sv
// Synchronous FIFO with flush; head word is presented combinationally on dout.
module debug_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_i,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign empty   = (level == '0);
   assign full    = (level == (AW+1)'(DEPTH));
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   // Storage array; contents need no reset since level gates visibility.
   always_ff @(posedge wb_clk_i) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointer and occupancy bookkeeping; flush overrides any pop or push.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end
endmodule

// File: rtl/debug_console_wb.sv
// Wishbone debug console: TX byte FIFO drained over valid/ready plus a test-result mailbox.
module debug_console_wb
   import debug_console_pkg::*;
#(
   parameter int          FIFO_DEPTH  = 16,
   parameter logic [31:0] PASS_CODE   = DEF_PASS_CODE,
   parameter logic [31:0] FAIL_CODE   = DEF_FAIL_CODE,
   parameter logic [31:0] FINISH_CODE = DEF_FINISH_CODE
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   debug_console_wb_if.slave wb,
   output logic [7:0]        tx_data_o,
   output logic              tx_valid_o,
   input  logic              tx_ready_i,
   output logic              done_o,
   output logic              pass_o,
   output logic              finish_o
);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   logic [2:0]            reg_idx;
   logic                  req, txdata_wr, stall, accept, is_err;
   logic                  push, flush, wr_result;
   logic                  fifo_empty, fifo_full;
   logic [LW-1:0]         fifo_level;
   logic [ST_LEVEL_W-1:0] level9;
   logic [31:0]           result_q, rdata;
   logic                  finish_pend;
   logic                  unused_bits;

   assign reg_idx   = wb.wb_adr_i[4:2];
   assign req       = wb.wb_cyc_i & wb.wb_stb_i;
   assign txdata_wr = req & wb.wb_we_i & (reg_idx == REG_TXDATA);
   // Stall only on a TXDATA write into a full FIFO; a same-cycle pop does not bypass.
   assign stall     = txdata_wr & fifo_full;
   assign accept    = req & ~stall;
   assign is_err    = reg_idx[2] | (wb.wb_we_i & (reg_idx == REG_TXDATA) & ~wb.wb_sel_i[0]);
   assign push      = accept & txdata_wr & wb.wb_sel_i[0];
   assign flush     = accept & wb.wb_we_i & (reg_idx == REG_CTRL) & wb.wb_dat_i[0];
   assign wr_result = accept & wb.wb_we_i & (reg_idx == REG_RESULT);

   assign wb.wb_stall_o = stall;
   assign tx_valid_o    = ~fifo_empty;
   assign level9        = ST_LEVEL_W'(fifo_level);
   assign unused_bits   = &{1'b0, wb.wb_adr_i[31:5], wb.wb_adr_i[1:0], wb.wb_sel_i[3:1]};

   debug_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .push     (push),
      .pop      (tx_ready_i),
      .flush    (flush),
      .din      (wb.wb_dat_i[7:0]),
      .dout     (tx_data_o),
      .empty    (fifo_empty),
      .full     (fifo_full),
      .level    (fifo_level)
   );

   // Read mux; TXDATA, CTRL and undecoded slots read as zero.
   always_comb begin
      rdata = '0;
      case (reg_idx)
         REG_STATUS: rdata = pack_status(level9, fifo_empty, fifo_full, done_o, pass_o, finish_o);
         REG_RESULT: rdata = result_q;
         default:    rdata = '0;
      endcase
   end

   // Single-cycle registered response; data bus is zero outside read acks.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wb.wb_ack_o <= 1'b0;
         wb.wb_err_o <= 1'b0;
         wb.wb_dat_o <= '0;
      end else begin
         wb.wb_ack_o <= accept & ~is_err;
         wb.wb_err_o <= accept & is_err;
         wb.wb_dat_o <= (accept & ~is_err & ~wb.wb_we_i) ? rdata : '0;
      end
   end

   // Result mailbox: verdict flags are sticky, finish waits for the FIFO to drain.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         result_q    <= '0;
         done_o      <= 1'b0;
         pass_o      <= 1'b0;
         finish_pend <= 1'b0;
         finish_o    <= 1'b0;
      end else begin
         if (wr_result) begin
            result_q <= wb.wb_dat_i;
            if (wb.wb_dat_i == PASS_CODE) begin
               done_o <= 1'b1;
               pass_o <= 1'b1;
            end else if (wb.wb_dat_i == FAIL_CODE) begin
               done_o <= 1'b1;
               pass_o <= 1'b0;
            end else if (wb.wb_dat_i == FINISH_CODE) begin
               done_o      <= 1'b1;
               finish_pend <= 1'b1;
            end
         end
         finish_o <= finish_o | (finish_pend & fifo_empty);
      end
   end
endmodule

// File: tb/tb_debug_console_wb.sv
// Self-checking bench for debug_console_wb: vector table, corner sequences, random ops vs model.
module tb_debug_console_wb;
   localparam int          DEPTH  = 16;
   localparam logic [31:0] C_PASS = 32'h1;
   localparam logic [31:0] C_FAIL = 32'h0;
   localparam logic [31:0] C_FIN  = 32'h90;

   logic       wb_clk_i = 1'b0;
   logic       wb_rst_i = 1'b1;
   logic [7:0] tx_data_o;
   logic       tx_valid_o, tx_ready_i, done_o, pass_o, finish_o;

   always #5 wb_clk_i = ~wb_clk_i;

   debug_console_wb_if wb();

   debug_console_wb #(.FIFO_DEPTH(DEPTH), .PASS_CODE(C_PASS), .FAIL_CODE(C_FAIL),
                      .FINISH_CODE(C_FIN)) dut (
      .wb_clk_i   (wb_clk_i),
      .wb_rst_i   (wb_rst_i),
      .wb         (wb),
      .tx_data_o  (tx_data_o),
      .tx_valid_o (tx_valid_o),
      .tx_ready_i (tx_ready_i),
      .done_o     (done_o),
      .pass_o     (pass_o),
      .finish_o   (finish_o)
   );

   int checks = 0;
   int errors = 0;
   int rx_count = 0;

   // Reference model: a byte queue for the FIFO plus the mailbox state.
   logic [7:0]  mq[$];
   logic [31:0] m_result = '0;
   logic        m_done = 0, m_pass = 0, m_pend = 0, m_finish = 0;

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic        e_ack;
      logic        e_err;
      logic [31:0] e_dat;
      string       name;
   } vec_t;
   vec_t tbl[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] m_status();
      logic [31:0] s;
      s     = 32'(mq.size());
      s[16] = (mq.size() == 0);
      s[17] = (mq.size() == DEPTH);
      s[24] = m_done;
      s[25] = m_pass;
      s[26] = m_finish;
      return s;
   endfunction

   function automatic void m_expect(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                                    output logic e_ack, output logic e_err, output logic [31:0] e_dat);
      int idx;
      idx   = int'(adr[4:2]);
      e_err = (idx >= 4) || (we && idx == 0 && !sel[0]);
      e_ack = !e_err;
      e_dat = '0;
      if (!we && !e_err) begin
         if (idx == 1) e_dat = m_status();
         if (idx == 2) e_dat = m_result;
      end
   endfunction

   function automatic void m_update(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                                    input logic [3:0] sel);
      int idx;
      idx = int'(adr[4:2]);
      if (!we) return;
      if (idx == 0 && sel[0]) mq.push_back(dat[7:0]);
      if (idx == 3 && dat[0]) mq.delete();
      if (idx == 2) begin
         m_result = dat;
         if (dat == C_PASS) begin m_done = 1; m_pass = 1; end
         else if (dat == C_FAIL) begin m_done = 1; m_pass = 0; end
         else if (dat == C_FIN) begin m_done = 1; m_pend = 1; end
      end
   endfunction

   // Sink monitor: each handshake must deliver the oldest byte the model holds.
   always begin
      @(negedge wb_clk_i);
      #1;
      if (!wb_rst_i && tx_valid_o && tx_ready_i) begin
         if (mq.size() == 0) check("tx_extra_byte", 32'(tx_data_o), 32'hFFFF_FFFF);
         else check("tx_byte", 32'(tx_data_o), 32'(mq.pop_front()));
         rx_count++;
      end
   end

   // One bus transaction, called on a falling edge; returns on the falling edge after accept.
   task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic rdy,
                       output logic ack, output logic err, output logic [31:0] rdat, output logic ok);
      int n;
      wb.wb_cyc_i = 1; wb.wb_stb_i = 1; wb.wb_we_i = we;
      wb.wb_adr_i = adr; wb.wb_dat_i = dat; wb.wb_sel_i = sel;
      tx_ready_i  = rdy;
      ok = 1; n = 0; ack = 0; err = 0; rdat = '0;
      #1;
      while (wb.wb_stall_o) begin
         if (n == 200) begin ok = 0; break; end
         @(negedge wb_clk_i); #1; n++;
      end
      if (ok) begin
         @(negedge wb_clk_i);
         ack = wb.wb_ack_o; err = wb.wb_err_o; rdat = wb.wb_dat_o;
      end
      wb.wb_cyc_i = 0; wb.wb_stb_i = 0; wb.wb_we_i = 0;
   endtask

   task automatic op(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, input logic rdy, input string nm);
      logic e_ack, e_err, a, e, ok;
      logic [31:0] e_dat, d;
      m_expect(we, adr, sel, e_ack, e_err, e_dat);
      xfer(we, adr, dat, sel, rdy, a, e, d, ok);
      check({nm, "_accepted"}, 32'(ok), 32'd1);
      if (!ok) return;
      check({nm, "_ack"}, 32'(a), 32'(e_ack));
      check({nm, "_err"}, 32'(e), 32'(e_err));
      check({nm, "_dat"}, d, e_dat);
      m_update(we, adr, dat, sel);
   endtask

   task automatic drain(input string nm);
      tx_ready_i = 1;
      for (int i = 0; i < 60; i++) begin
         @(negedge wb_clk_i);
         if (mq.size() == 0 && !tx_valid_o) break;
      end
      tx_ready_i = 0;
      check({nm, "_model_empty"}, 32'(mq.size()), 32'd0);
      check({nm, "_tx_valid"}, 32'(tx_valid_o), 32'd0);
   endtask

   task automatic add(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input logic ack, input logic err,
                      input logic [31:0] edat, input string nm);
      vec_t v;
      v.we = we; v.adr = adr; v.dat = dat; v.sel = sel;
      v.e_ack = ack; v.e_err = err; v.e_dat = edat; v.name = nm;
      tbl.push_back(v);
   endtask

   initial begin
      logic a, e, ok;
      logic [31:0] d, adr, dat;
      logic [3:0] sel;
      logic [7:0] b17;
      int rx0, r, idx;
      logic rdy;

      wb.wb_cyc_i = 0; wb.wb_stb_i = 0; wb.wb_we_i = 0;
      wb.wb_adr_i = '0; wb.wb_dat_i = '0; wb.wb_sel_i = '0;
      tx_ready_i = 0;

      add(0, 32'h04, 32'h0,   4'hF, 1, 0, 32'h0001_0000, "st_reset");
      add(1, 32'h00, 32'h48,  4'hF, 1, 0, 32'h0,         "tx_H");
      add(1, 32'h00, 32'h69,  4'h1, 1, 0, 32'h0,         "tx_i");
      add(0, 32'h04, 32'h0,   4'hF, 1, 0, 32'h0000_0002, "st_lvl2");
      add(1, 32'h00, 32'h77,  4'h2, 0, 1, 32'h0,         "tx_badsel");
      add(0, 32'h04, 32'h0,   4'hF, 1, 0, 32'h0000_0002, "st_lvl_kept");
      add(0, 32'h10, 32'h0,   4'hF, 0, 1, 32'h0,         "rd_adr10");
      add(1, 32'h10, 32'h1,   4'hF, 0, 1, 32'h0,         "wr_adr10");
      add(1, 32'h1C, 32'h1,   4'hF, 0, 1, 32'h0,         "wr_adr1c");
      add(0, 32'h04, 32'h0,   4'hF, 1, 0, 32'h0000_0002, "st_after_err");
      add(1, 32'h08, 32'h1,   4'hF, 1, 0, 32'h0,         "res_pass");
      add(0, 32'h04, 32'h0,   4'hF, 1, 0, 32'h0300_0002, "st_pass");
      add(1, 32'h08, 32'h0,   4'hF, 1, 0, 32'h0,         "res_fail");
      add(0, 32'h04, 32'h0,   4'hF, 1, 0, 32'h0100_0002, "st_fail");
      add(1, 32'h08, 32'h55,  4'h0, 1, 0, 32'h0,         "res_other");
      add(0, 32'h08, 32'h0,   4'hF, 1, 0, 32'h0000_0055, "res_rd55");
      add(0, 32'h04, 32'h0,   4'hF, 1, 0, 32'h0100_0002, "st_other");
      add(0, 32'h00, 32'h0,   4'hF, 1, 0, 32'h0,         "txdata_rd");
      add(0, 32'h0C, 32'h0,   4'hF, 1, 0, 32'h0,         "ctrl_rd");
      add(1, 32'h04, 32'hFFFF_FFFF, 4'hF, 1, 0, 32'h0,   "status_wr");
      add(0, 32'h8000_0004, 32'h0, 4'hF, 1, 0, 32'h0100_0002, "st_hiaddr");
      add(1, 32'h0C, 32'h0,   4'hF, 1, 0, 32'h0,         "ctrl_noflush");
      add(0, 32'h04, 32'h0,   4'hF, 1, 0, 32'h0100_0002, "st_noflush");

      // Reset state, then reset landing between accept and response.
      @(negedge wb_clk_i);
      check("rst_ack", 32'(wb.wb_ack_o), 0);
      check("rst_err", 32'(wb.wb_err_o), 0);
      check("rst_dat", wb.wb_dat_o, 0);
      check("rst_stall", 32'(wb.wb_stall_o), 0);
      check("rst_flags", {28'd0, tx_valid_o, done_o, pass_o, finish_o}, 0);
      wb_rst_i = 0;
      @(negedge wb_clk_i);
      wb.wb_cyc_i = 1; wb.wb_stb_i = 1; wb.wb_we_i = 1;
      wb.wb_adr_i = 32'h08; wb.wb_dat_i = C_PASS; wb.wb_sel_i = 4'hF;
      @(posedge wb_clk_i);
      #2 wb_rst_i = 1;
      @(negedge wb_clk_i);
      check("midrst_ack_err", {30'd0, wb.wb_ack_o, wb.wb_err_o}, 0);
      check("midrst_done_pass", {30'd0, done_o, pass_o}, 0);
      wb.wb_cyc_i = 0; wb.wb_stb_i = 0; wb.wb_we_i = 0;
      wb_rst_i = 0;
      @(negedge wb_clk_i);

      // Vector table with the sink stalled.
      foreach (tbl[i]) begin
         xfer(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, 1'b0, a, e, d, ok);
         check({tbl[i].name, "_accepted"}, 32'(ok), 1);
         check({tbl[i].name, "_ack"}, 32'(a), 32'(tbl[i].e_ack));
         check({tbl[i].name, "_err"}, 32'(e), 32'(tbl[i].e_err));
         check({tbl[i].name, "_dat"}, d, tbl[i].e_dat);
         if (ok) m_update(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel);
      end
      rx0 = rx_count;
      drain("drain_hi");
      check("drain_hi_count", 32'(rx_count - rx0), 2);
      op(0, 32'h04, 0, 4'hF, 0, "st_after_hi");

      // Back-to-back reads give back-to-back acks.
      wb.wb_cyc_i = 1; wb.wb_stb_i = 1; wb.wb_we_i = 0; wb.wb_adr_i = 32'h08; wb.wb_sel_i = 4'hF;
      @(negedge wb_clk_i);
      check("b2b_ack0", {31'd0, wb.wb_ack_o}, 1);
      check("b2b_dat0", wb.wb_dat_o, 32'h55);
      @(negedge wb_clk_i);
      check("b2b_ack1", {31'd0, wb.wb_ack_o}, 1);
      wb.wb_cyc_i = 0; wb.wb_stb_i = 0;
      @(negedge wb_clk_i);
      check("b2b_idle", {30'd0, wb.wb_ack_o, wb.wb_err_o}, 0);
      check("b2b_idle_dat", wb.wb_dat_o, 0);

      // Fill the FIFO, stall the 17th write, release for exactly one cycle.
      rx0 = rx_count;
      for (int i = 0; i < DEPTH; i++) op(1, 32'h00, 32'($urandom_range(0, 255)), 4'hF, 0, "fill");
      op(0, 32'h04, 0, 4'hF, 0, "st_full");
      check("full_flag", 32'(m_status() >> 17) & 1, 1);
      b17 = 8'hA5;
      wb.wb_cyc_i = 1; wb.wb_stb_i = 1; wb.wb_we_i = 1;
      wb.wb_adr_i = 32'h0; wb.wb_dat_i = {24'd0, b17}; wb.wb_sel_i = 4'h1;
      for (int i = 0; i < 3; i++) begin
         #1 check("stall_full", {31'd0, wb.wb_stall_o}, 1);
         @(negedge wb_clk_i);
         check("stall_no_ack", {31'd0, wb.wb_ack_o}, 0);
      end
      tx_ready_i = 1;
      #1 check("stall_no_bypass", {31'd0, wb.wb_stall_o}, 1);
      @(negedge wb_clk_i);
      tx_ready_i = 0;
      #1 check("stall_released", {31'd0, wb.wb_stall_o}, 0);
      @(negedge wb_clk_i);
      check("ack_17th", {31'd0, wb.wb_ack_o}, 1);
      wb.wb_cyc_i = 0; wb.wb_stb_i = 0; wb.wb_we_i = 0;
      mq.push_back(b17);
      drain("drain_17");
      check("drain_17_count", 32'(rx_count - rx0), 17);

      // FINISH only reaches finish_o once the queued bytes are gone.
      for (int i = 0; i < 3; i++) op(1, 32'h00, 32'h30 + 32'(i), 4'hF, 0, "fin_q");
      op(1, 32'h08, C_FIN, 4'hF, 0, "res_finish");
      for (int i = 0; i < 3; i++) begin
         @(negedge wb_clk_i);
         check("finish_held", {31'd0, finish_o}, 0);
      end
      tx_ready_i = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge wb_clk_i);
         if (!tx_valid_o) break;
      end
      check("finish_empty_valid", {31'd0, tx_valid_o}, 0);
      check("finish_not_yet", {31'd0, finish_o}, 0);
      @(negedge wb_clk_i);
      tx_ready_i = 0;
      check("finish_rise", {31'd0, finish_o}, 1);
      check("finish_done_pass", {30'd0, done_o, pass_o}, 32'b10);
      m_finish = 1;
      op(0, 32'h04, 0, 4'hF, 0, "st_finish");

      // CTRL flush with entries queued.
      for (int i = 0; i < 5; i++) op(1, 32'h00, 32'h40 + 32'(i), 4'hF, 0, "flush_q");
      op(1, 32'h0C, 32'h1, 4'hF, 0, "ctrl_flush");
      check("flush_valid", {31'd0, tx_valid_o}, 0);
      op(0, 32'h04, 0, 4'hF, 0, "st_flushed");

      // Random operations against the model.
      for (int n = 0; n < 300; n++) begin
         r   = $urandom_range(0, 99);
         sel = 4'hF; dat = $urandom; rdy = 1'($urandom_range(0, 1));
         if (r < 35) begin
            idx = 0; sel = 4'($urandom_range(0, 15));
            if (mq.size() == DEPTH) rdy = 1;
            adr = ($urandom & 32'hFFFF_FFE3) | 32'(idx << 2);
            op(1, adr, dat, sel, rdy, "rnd_tx");
         end else if (r < 50) begin
            adr = ($urandom & 32'hFFFF_FFE3) | 32'h4;
            op(0, adr, dat, sel, 0, "rnd_status");
         end else if (r < 62) begin
            case ($urandom_range(0, 3))
               0: dat = C_PASS;
               1: dat = C_FAIL;
               2: dat = C_FIN;
               default: dat = $urandom;
            endcase
            op(1, 32'h08, dat, 4'($urandom_range(0, 15)), rdy, "rnd_res_wr");
         end else if (r < 72) begin
            op(0, 32'h08, dat, sel, rdy, "rnd_res_rd");
         end else if (r < 78) begin
            op(1, 32'h0C, dat, sel, rdy, "rnd_ctrl");
         end else if (r < 88) begin
            idx = $urandom_range(4, 7);
            adr = ($urandom & 32'hFFFF_FFE3) | 32'(idx << 2);
            op(1'($urandom_range(0, 1)), adr, dat, sel, rdy, "rnd_bad");
         end else begin
            idx = $urandom_range(0, 3);
            if (idx == 1) rdy = 0;
            op(idx == 1, 32'(idx << 2), dat, sel, rdy, "rnd_misc");
         end
         check("rnd_done", {31'd0, done_o}, 32'(m_done));
         check("rnd_pass", {31'd0, pass_o}, 32'(m_pass));
      end
      drain("drain_final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
